toggle_pulse_gen: RTL and testbench

//  Upstream stage of toggle_ff: turns a raw, asynchronous, bouncing push-button level into
//  a clean single-cycle pulse t_out that drives toggle_ff.t_in. One press gives exactly one toggle.

---
 rtl/toggle_pulse_gen_pkg.sv | 33 +++
 rtl/toggle_pulse_gen_sync_chain.sv | 35 +++
 rtl/toggle_pulse_gen.sv | 107 ++++++++++
 tb/tb_toggle_pulse_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/toggle_pulse_gen_pkg.sv
// rtl/toggle_pulse_gen_pkg.sv - shared state encodings and parameter checks for button-input blocks
//
// Contents:
//   btn_state_t     debounce FSM state encoding (reused by other button-input blocks)
//   *_MIN           lowest legal values of the block parameters
//   params_legal()  true when a parameter set is usable
//   cnt_width()     width of a counter that must reach DEBOUNCE_CYCLES
package toggle_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_WAIT_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_WAIT_L = 2'd3
    } btn_state_t;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int DEBOUNCE_CYCLES_MIN = 1;

    function automatic bit params_legal(input int sync_stages, input int debounce_cycles);
        return (sync_stages >= SYNC_STAGES_MIN) && (debounce_cycles >= DEBOUNCE_CYCLES_MIN);
    endfunction

    // Counter width able to hold 0..debounce_cycles; clamped so an illegal
    // value still gives a non-zero width while the legality check reports it.
    function automatic int cnt_width(input int debounce_cycles);
        if (debounce_cycles < DEBOUNCE_CYCLES_MIN) begin
            return 1;
        end
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/toggle_pulse_gen_sync_chain.sv
// rtl/toggle_pulse_gen_sync_chain.sv - plain flop chain for bringing an asynchronous level into clk
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears every stage
//   d      in   asynchronous input level
//   q      out  d delayed by STAGES rising edges (last stage)
module sync_chain
    import toggle_pulse_gen_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("sync_chain: STAGES must be at least 2");
    end

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/toggle_pulse_gen.sv
// rtl/toggle_pulse_gen.sv - button debouncer producing one clean t_out pulse per accepted edge
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset; wins over everything, drops a pending edge
//   btn_in  in   raw button level, asynchronous, may bounce
//   t_out   out  registered single-cycle pulse per accepted press (and release if enabled)
//   level   out  registered debounced button level
//   busy    out  high while a candidate edge is being qualified
module toggle_pulse_gen
    import toggle_pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter bit PULSE_ON_RELEASE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic t_out,
    output logic level,
    output logic busy
);

    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("toggle_pulse_gen: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s)
    );

    // level/busy are loaded with the value that matches the next state, so
    // they are registered yet always consistent with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOW;
            cnt   <= '0;
            t_out <= 1'b0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            t_out <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (s) begin
                        state <= ST_WAIT_H;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT_H: begin
                    if (!s) begin
                        state <= ST_LOW;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_HIGH;
                        t_out <= 1'b1;
                        level <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        state <= ST_WAIT_L;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT_L: begin
                    if (s) begin
                        state <= ST_HIGH;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_LOW;
                        t_out <= PULSE_ON_RELEASE;
                        level <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// tb/tb_toggle_pulse_gen.sv - scoreboard bench for toggle_pulse_gen feeding a toggle flop
module tb_toggle_pulse_gen;

    localparam int S   = 2;
    localparam int D   = 4;
    localparam int LAT = S + D;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic t_out0, level0, busy0;
    logic t_out1, level1, busy1;
    logic q0, q1;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    logic saw_busy;

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;
    int exp_q0[$];
    int exp_q1[$];

    always #5 clk = ~clk;

    toggle_pulse_gen #(
        .SYNC_STAGES      (S),
        .DEBOUNCE_CYCLES  (D),
        .PULSE_ON_RELEASE (1'b0)
    ) dut0 (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .t_out  (t_out0),
        .level  (level0),
        .busy   (busy0)
    );

    toggle_pulse_gen #(
        .SYNC_STAGES      (S),
        .DEBOUNCE_CYCLES  (D),
        .PULSE_ON_RELEASE (1'b1)
    ) dut1 (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .t_out  (t_out1),
        .level  (level1),
        .busy   (busy1)
    );

    // Downstream toggle flops driven by each instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            q0 <= 1'b0;
            q1 <= 1'b0;
        end else begin
            if (t_out0) q0 <= ~q0;
            if (t_out1) q1 <= ~q1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulse monitor: every t_out cycle must match the head of its expectation queue.
    always @(negedge clk) begin
        if (t_out0) begin
            check_eq("t_out0_back_to_back", 32'(prev0), 0);
            if (exp_q0.size() == 0) check_eq("t_out0_spurious", 32'(exp_q0.size()), 1);
            else                    check_eq("t_out0_cycle", cyc, exp_q0.pop_front());
        end
        if (t_out1) begin
            check_eq("t_out1_back_to_back", 32'(prev1), 0);
            if (exp_q1.size() == 0) check_eq("t_out1_spurious", 32'(exp_q1.size()), 1);
            else                    check_eq("t_out1_cycle", cyc, exp_q1.pop_front());
        end
        prev0 = t_out0;
        prev1 = t_out1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; the next rising edge is the first to sample v.
    task automatic drive_btn(input logic v, input bit exp0, input bit exp1);
        btn_in = v;
        if (exp0) exp_q0.push_back(cyc + 1 + LAT);
        if (exp1) exp_q1.push_back(cyc + 1 + LAT);
    endtask

    task automatic check_queues(input string tag);
        check_eq({tag, "_q0_drained"}, 32'(exp_q0.size()), 0);
        check_eq({tag, "_q1_drained"}, 32'(exp_q1.size()), 0);
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;

        // reset held two cycles
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_t_out", 32'(t_out0), 0);
            check_eq("rst_level", 32'(level0), 0);
            check_eq("rst_busy",  32'(busy0),  0);
        end
        reset = 1'b0;
        wait_cyc(2);
        check_eq("rst_q0", 32'(q0), 0);

        // clean press, then release
        drive_btn(1'b1, 1, 1);
        wait_cyc(20);
        check_eq("press_level", 32'(level0), 1);
        check_eq("press_busy",  32'(busy0),  0);
        check_eq("press_q0",    32'(q0),     1);
        check_eq("press_q1",    32'(q1),     1);
        drive_btn(1'b0, 0, 1);
        wait_cyc(20);
        check_eq("release_level", 32'(level0), 0);
        check_eq("release_q0",    32'(q0),     1);
        check_eq("release_q1",    32'(q1),     0);
        check_queues("press");

        // bounce 1/0/1/0 two cycles each, then hold high
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                if (busy0) saw_busy = 1'b1;
            end
        end
        drive_btn(1'b1, 1, 1);
        wait_cyc(20);
        check_eq("bounce_busy_seen", 32'(saw_busy), 1);
        check_eq("bounce_busy_done", 32'(busy0),    0);
        check_eq("bounce_level",     32'(level1),   1);
        check_eq("bounce_q0",        32'(q0),       0);
        check_eq("bounce_q1",        32'(q1),       1);
        drive_btn(1'b0, 0, 1);
        wait_cyc(20);
        check_eq("bounce_rel_q1", 32'(q1), 0);
        check_queues("bounce");

        // glitches of 3 and 4 cycles (one short of acceptance) are ignored
        for (int w = 3; w <= 4; w++) begin
            drive_btn(1'b1, 0, 0);
            wait_cyc(w);
            drive_btn(1'b0, 0, 0);
            wait_cyc(15);
            check_eq("glitch_level", 32'(level0), 0);
            check_eq("glitch_q0",    32'(q0),     0);
            check_eq("glitch_q1",    32'(q1),     0);
        end

        // 5-cycle press: shortest accepted width
        drive_btn(1'b1, 1, 1);
        wait_cyc(5);
        drive_btn(1'b0, 0, 1);
        wait_cyc(20);
        check_eq("min_press_q0",    32'(q0),     1);
        check_eq("min_press_q1",    32'(q1),     0);
        check_eq("min_press_level", 32'(level0), 0);
        check_queues("min_press");

        // reset two cycles into WAIT_H with the button held
        drive_btn(1'b1, 0, 0);
        wait_cyc(4);
        check_eq("midq_busy_before", 32'(busy0), 1);
        reset = 1'b1;
        wait_cyc(1);
        check_eq("midq_busy_in_rst", 32'(busy0), 0);
        wait_cyc(1);
        reset = 1'b0;
        drive_btn(1'b1, 1, 1);
        wait_cyc(20);
        check_eq("midq_q0",    32'(q0),     1);
        check_eq("midq_q1",    32'(q1),     1);
        check_eq("midq_level", 32'(level0), 1);
        check_queues("midq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
